// File: rtl/neuron_mac_sequencer.sv
// Time-shares one neuron MAC across N_NEURONS logical neurons: clears it, streams
// N_INPUTS weight/input pairs from 1-cycle-latency memories, then latches its activation.
module neuron_mac_sequencer #(
    parameter int WIDTH     = 8,
    parameter int N_INPUTS  = 4,
    parameter int N_NEURONS = 4,
    localparam int WA_W = (N_NEURONS * N_INPUTS > 1) ? $clog2(N_NEURONS * N_INPUTS) : 1,
    localparam int XA_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [N_NEURONS-1:0] result_o,
    output logic [WA_W-1:0]      w_addr_o,
    input  logic [WIDTH-1:0]     w_rdata_i,
    output logic [XA_W-1:0]      x_addr_o,
    input  logic [WIDTH-1:0]     x_rdata_i,
    output logic                 neuron_rst_n_o,
    output logic                 neuron_en_o,
    output logic [WIDTH-1:0]     neuron_w_o,
    output logic [WIDTH-1:0]     neuron_x_o,
    input  logic                 neuron_out_i
);

    localparam int NI_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACC,
        S_CAPTURE,
        S_DONE
    } state_e;

    state_e                 state_q;
    logic [NI_W-1:0]        nidx_q;
    logic [XA_W-1:0]        iidx_q;
    logic                   busy_q;
    logic                   done_q;
    logic [N_NEURONS-1:0]   result_q;
    logic [WA_W-1:0]        w_addr_q;
    logic [XA_W-1:0]        x_addr_q;
    logic                   nrst_n_q;
    logic                   en_q;

    logic                   last_input;
    logic                   last_neuron;
    int                     ahead_d;
    logic [WA_W-1:0]        w_base;
    logic [WA_W-1:0]        w_base_nxt;
    logic [WA_W-1:0]        w_addr_d;
    logic [XA_W-1:0]        x_addr_d;

    assign last_input  = (iidx_q == XA_W'(N_INPUTS - 1));
    assign last_neuron = (nidx_q == NI_W'(N_NEURONS - 1));
    assign w_base      = WA_W'(32'(nidx_q) * 32'(N_INPUTS));
    assign w_base_nxt  = WA_W'((32'(nidx_q) + 32'd1) * 32'(N_INPUTS));

    // Addresses run one input ahead of the operand in flight, saturating on the last input.
    always_comb begin
        ahead_d = N_INPUTS - 1;
        if (state_q == S_CLEAR) begin
            ahead_d = (N_INPUTS > 1) ? 1 : 0;
        end else if (int'(iidx_q) + 2 < N_INPUTS) begin
            ahead_d = int'(iidx_q) + 2;
        end
        w_addr_d = w_base + WA_W'(ahead_d);
        x_addr_d = XA_W'(ahead_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            nidx_q   <= '0;
            iidx_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            w_addr_q <= '0;
            x_addr_q <= '0;
            nrst_n_q <= 1'b0;
            en_q     <= 1'b0;
        end else if (abort_i && (state_q != S_IDLE)) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            en_q     <= 1'b0;
            nrst_n_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    en_q     <= 1'b0;
                    done_q   <= 1'b0;
                    nrst_n_q <= 1'b1;
                    if (start_i && !abort_i) begin
                        state_q  <= S_CLEAR;
                        busy_q   <= 1'b1;
                        result_q <= '0;
                        nidx_q   <= '0;
                        iidx_q   <= '0;
                        w_addr_q <= '0;
                        x_addr_q <= '0;
                        nrst_n_q <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    state_q  <= S_ACC;
                    nrst_n_q <= 1'b1;
                    en_q     <= 1'b1;
                    iidx_q   <= '0;
                    w_addr_q <= w_addr_d;
                    x_addr_q <= x_addr_d;
                end
                S_ACC: begin
                    if (last_input) begin
                        state_q <= S_CAPTURE;
                        en_q    <= 1'b0;
                    end else begin
                        iidx_q   <= iidx_q + XA_W'(1);
                        w_addr_q <= w_addr_d;
                        x_addr_q <= x_addr_d;
                    end
                end
                S_CAPTURE: begin
                    for (int i = 0; i < N_NEURONS; i++) begin
                        if (nidx_q == NI_W'(i)) begin
                            result_q[i] <= neuron_out_i;
                        end
                    end
                    if (last_neuron) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= S_CLEAR;
                        nidx_q   <= nidx_q + NI_W'(1);
                        iidx_q   <= '0;
                        nrst_n_q <= 1'b0;
                        w_addr_q <= w_base_nxt;
                        x_addr_q <= '0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign result_o       = result_q;
    assign w_addr_o       = w_addr_q;
    assign x_addr_o       = x_addr_q;
    assign neuron_rst_n_o = nrst_n_q;
    assign neuron_en_o    = en_q;
    // Operands pass straight through from the memories; zero outside accumulate cycles.
    assign neuron_w_o     = en_q ? w_rdata_i : '0;
    assign neuron_x_o     = en_q ? x_rdata_i : '0;

endmodule
